instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 28 ++
 rtl/instr_fetch_perf_counter.sv | 44 ++++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared CPU front-end definitions used by the instruction fetch unit:
//   - fetch_state_e : fetch FSM state encoding (BOOT, FETCH, HOLD, DRAIN)
//   - PC_STEP       : byte distance between sequential instructions
//   - RESET_PC      : value the program counter holds while in reset
//   - INSTR_W       : instruction word width
//   - align_target  : word-aligns a branch/redirect target
// Optional feature macro used by the fetch unit: FETCH_PERF_EN.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// Optional fetch performance counters, only built when FETCH_PERF_EN is
// defined.
// Ports:
//   clk_i          : clock, counters update on rising edge
//   rst_i          : asynchronous active-high reset, clears both counters
//   accept_i       : one instruction handed to decode this cycle
//   stall_i        : fetch request outstanding and not acknowledged this cycle
//   fetch_count_o  : number of accepted instructions (wraps at 2^32)
//   stall_count_o  : number of memory stall cycles (wraps at 2^32)
// -----------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
module fetch_perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        accept_i,
    input  logic        stall_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] fetch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept_i) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (stall_i) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign fetch_count_o = fetch_q;
    assign stall_count_o = stall_q;

endmodule
`endif

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: drives the next-PC value for an external program
// counter register, issues requests to instruction memory, and presents the
// fetched word to decode with a valid/ready handshake. Branch redirects
// (brTaken) override every other event.
// Optional feature: FETCH_PERF_EN adds fetchCount/stallCount counters.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   instrAddr          : current PC (from the external PC register)
//   nextInstrAddr      : PC value to load on the next edge
//   brTaken, brTarget  : redirect pulse and target address
//   imemReq, imemAddr  : instruction memory request and address
//   imemAck, imemRdata : instruction memory acknowledge and read data
//   instrValid, instrReady, instr, instrPC : decode handshake
//   fetchCount, stallCount (FETCH_PERF_EN only) : performance counters
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instrAddr,
    output logic [31:0]        nextInstrAddr,
    input  logic               brTaken,
    input  logic [31:0]        brTarget,
    output logic               imemReq,
    output logic [31:0]        imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemRdata,
    output logic               instrValid,
    input  logic               instrReady,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instrPC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetchCount,
    output logic [31:0]        stallCount
`endif
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic [31:0]        next_pc;
    logic [31:0]        pc_plus_step;
    logic [31:0]        br_pc;

    assign pc_plus_step = instrAddr + PC_STEP;
    assign br_pc        = align_target(brTarget);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        next_pc    = instrAddr;

        case (state_q)
            ST_BOOT: begin
                // imemAck here can only be stale from before reset: ignored.
                next_pc = pc_plus_step;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imemAck) begin
                    instr_d    = imemRdata;
                    instr_pc_d = instrAddr;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instrReady) begin
                    next_pc = pc_plus_step;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imemAck) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect overrides everything above. A request still in flight must
        // complete before the new target is fetched, so an unacknowledged
        // FETCH (or an existing DRAIN) moves to DRAIN; otherwise refetch.
        if (brTaken) begin
            next_pc    = br_pc;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            if ((state_q == ST_DRAIN) || ((state_q == ST_FETCH) && !imemAck)) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign nextInstrAddr = next_pc;
    assign imemReq       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imemAddr      = instrAddr;
    assign instrValid    = (state_q == ST_HOLD);
    assign instr         = instr_q;
    assign instrPC       = instr_pc_q;

`ifdef FETCH_PERF_EN
    logic accept;
    logic stall;

    // A redirect in HOLD drops the held word, so it is not counted as accepted.
    assign accept = instrValid && instrReady && !brTaken;
    assign stall  = imemReq && !imemAck;

    fetch_perf_counter u_perf (
        .clk_i         (clk),
        .rst_i         (rst),
        .accept_i      (accept),
        .stall_i       (stall),
        .fetch_count_o (fetchCount),
        .stall_count_o (stallCount)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instrAddr;
    logic [31:0] nextInstrAddr;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPC;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External program counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instrAddr <= RESET_PC;
        else     instrAddr <= nextInstrAddr;
    end

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .instrAddr     (instrAddr),
        .nextInstrAddr (nextInstrAddr),
        .brTaken       (brTaken),
        .brTarget      (brTarget),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemAck       (imemAck),
        .imemRdata     (imemRdata),
        .instrValid    (instrValid),
        .instrReady    (instrReady),
        .instr         (instr),
        .instrPC       (instrPC)
`ifdef FETCH_PERF_EN
        ,
        .fetchCount    (fetchCount),
        .stallCount    (stallCount)
`endif
    );

    // Reference state: memory responder and program-order scoreboard
    bit          auto_ack;
    int          lat;
    int          age;
    logic [31:0] exp_pc;
    int          accepts;
    int          fetch_exp;
    int          stall_exp;
    logic        prev_req, prev_ack, prev_valid, prev_ready, prev_br;
    logic [31:0] prev_instr, prev_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        exp_pc     = 32'h0;
        age        = 0;
        fetch_exp  = 0;
        stall_exp  = 0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_br    = 1'b0;
        prev_instr = '0;
        prev_pc    = '0;
    endtask

    // Evaluate one cycle: inputs already set by caller, apply protocol rules.
    task automatic eval();
        if (auto_ack) begin
            imemAck   = imemReq && (age >= lat);
            imemRdata = memfn(imemAddr);
        end
        #1;
        if (brTaken) chk("br_next", nextInstrAddr, {brTarget[31:2], 2'b00});
        if (imemReq) chk("imem_addr", imemAddr, instrAddr);
        if (prev_req && !prev_ack) chk("req_held", {31'b0, imemReq}, 32'd1);
        if (prev_valid && !prev_ready && !prev_br) begin
            chk("valid_held", {31'b0, instrValid}, 32'd1);
            chk("instr_held", instr, prev_instr);
            chk("pc_held", instrPC, prev_pc);
        end
        if (instrValid && instrReady && !brTaken) begin
            chk("acc_pc", instrPC, exp_pc);
            chk("acc_instr", instr, memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            fetch_exp++;
            accepts++;
        end
        if (brTaken) exp_pc = {brTarget[31:2], 2'b00};
        if (imemReq && !imemAck) stall_exp++;
        if (imemReq && !imemAck) age++;
        else                     age = 0;
        prev_req   = imemReq;
        prev_ack   = imemAck;
        prev_valid = instrValid;
        prev_ready = instrReady;
        prev_br    = brTaken;
        prev_instr = instr;
        prev_pc    = instrPC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        eval();
        while (!instrValid && n < 20) begin
            tick();
            eval();
            n++;
        end
        chk(tag, {31'b0, instrValid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          vcyc[$];
        logic [31:0] vpc[$];
        logic [31:0] fc_save;

        brTaken = 0; brTarget = 0; instrReady = 0; imemAck = 0; imemRdata = 0;
        auto_ack = 0; lat = 1; accepts = 0; fc_save = 0;
        reset_model();
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a stale ack present
        imemAck = 1;
        #1;
        chk("rst_req", {31'b0, imemReq}, 32'd0);
        chk("rst_valid", {31'b0, instrValid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instrPC, 32'd0);
        chk("rst_next", nextInstrAddr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_fc", fetchCount, 32'd0);
        chk("rst_sc", stallCount, 32'd0);
`endif
        imemAck = 0;
        tick();

        // Boot
        rst = 0; instrReady = 1; auto_ack = 1; lat = 1;
        eval();
        chk("boot_next", nextInstrAddr, 32'h0);
        chk("boot_req", {31'b0, imemReq}, 32'd0);
        tick();
        eval();
        chk("boot_fetch_req", {31'b0, imemReq}, 32'd1);
        chk("boot_fetch_addr", imemAddr, 32'h0);
        tick();

        // Streaming, ack latency 1, ready tied high
        for (int c = 3; c <= 10; c++) begin
            eval();
            if (instrValid) begin
                vcyc.push_back(c);
                vpc.push_back(instrPC);
            end
            tick();
        end
        chk("stream_n", vcyc.size(), 32'd3);
        for (int i = 0; i < vcyc.size(); i++) begin
            chk("stream_pc", vpc[i], 32'(4 * i));
            chk("stream_cyc", vcyc[i], 32'(4 + 3 * i));
        end
`ifdef FETCH_PERF_EN
        chk("stream_fc", fetchCount, 32'd3);
`endif

        // Backpressure in HOLD for 5 cycles
        instrReady = 0;
        wait_valid("bp_reach");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) eval();
            chk("bp_pc", instrPC, 32'hC);
            chk("bp_instr", instr, memfn(32'hC));
            chk("bp_next", nextInstrAddr, 32'hC);
            chk("bp_req", {31'b0, imemReq}, 32'd0);
            tick();
        end
        instrReady = 1;
        eval();
        chk("bp_release_next", nextInstrAddr, 32'h10);
        tick();

        // Redirect while a request is pending
        auto_ack = 0; imemAck = 0;
        eval();
        chk("rd_req", {31'b0, imemReq}, 32'd1);
        chk("rd_addr0", imemAddr, 32'h10);
        tick();
        brTaken = 1; brTarget = 32'h103;
        eval();
        chk("rd_next", nextInstrAddr, 32'h100);
        tick();
        brTaken = 0;
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("rd_drain_req", {31'b0, imemReq}, 32'd1);
            chk("rd_drain_valid", {31'b0, instrValid}, 32'd0);
            chk("rd_drain_addr", imemAddr, 32'h100);
            chk("rd_drain_next", nextInstrAddr, 32'h100);
            tick();
        end
        imemAck = 1; imemRdata = 32'hDEAD_BEEF;
        eval();
        chk("rd_ack_valid", {31'b0, instrValid}, 32'd0);
        tick();
        imemAck = 0;
        eval();
        chk("rd_after_valid", {31'b0, instrValid}, 32'd0);
        chk("rd_refetch_req", {31'b0, imemReq}, 32'd1);
        chk("rd_refetch_addr", imemAddr, 32'h100);
        tick();
        auto_ack = 1;
        wait_valid("rd_deliver");
        chk("rd_pc", instrPC, 32'h100);
        chk("rd_instr", instr, memfn(32'h100));
        tick();

        // Redirect coinciding with imemAck and instrReady (in FETCH)
        lat = 1;
        eval();
        tick();
        brTaken = 1; brTarget = 32'h204; instrReady = 1;
        eval();
        chk("sim_next", nextInstrAddr, 32'h204);
        tick();
        brTaken = 0;
        eval();
        chk("sim_valid", {31'b0, instrValid}, 32'd0);
        chk("sim_req", {31'b0, imemReq}, 32'd1);
        chk("sim_addr", imemAddr, 32'h204);
        tick();

        // Redirect coinciding with instrReady (in HOLD): word dropped
        instrReady = 0;
        wait_valid("sim2_reach");
        chk("sim2_pc", instrPC, 32'h204);
        tick();
`ifdef FETCH_PERF_EN
        fc_save = fetchCount;
`endif
        brTaken = 1; brTarget = 32'h300; instrReady = 1;
        eval();
        chk("sim2_next", nextInstrAddr, 32'h300);
        tick();
        brTaken = 0;
        eval();
        chk("sim2_valid", {31'b0, instrValid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("sim2_fc", fetchCount, fc_save);
`endif
        tick();

        // Reset while in DRAIN, stale ack afterwards, redirect in BOOT
        auto_ack = 0; imemAck = 0;
        eval();
        tick();
        brTaken = 1; brTarget = 32'h400;
        eval();
        tick();
        brTaken = 0;
        eval();
        chk("rm_drain_req", {31'b0, imemReq}, 32'd1);
        rst = 1;
        #1;
        chk("rm_req", {31'b0, imemReq}, 32'd0);
        chk("rm_valid", {31'b0, instrValid}, 32'd0);
        chk("rm_next", nextInstrAddr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rm_fc", fetchCount, 32'd0);
`endif
        reset_model();
        imemAck = 1;
        tick();
        rst = 0;
        brTaken = 1; brTarget = 32'h502;
        eval();
        chk("rm_boot_req", {31'b0, imemReq}, 32'd0);
        chk("rm_boot_next", nextInstrAddr, 32'h500);
        tick();
        brTaken = 0; imemAck = 0;
        eval();
        chk("rm_stale_valid", {31'b0, instrValid}, 32'd0);
        chk("rm_fetch_req", {31'b0, imemReq}, 32'd1);
        chk("rm_fetch_addr", imemAddr, 32'h500);
        tick();

        // Randomized traffic against the scoreboard
        auto_ack = 1;
        accepts = 0;
        for (int i = 0; i < 600; i++) begin
            lat        = int'($urandom_range(1, 3));
            instrReady = ($urandom % 4) != 0;
            brTaken    = ($urandom % 16) == 0;
            brTarget   = $urandom;
            eval();
            tick();
        end
        brTaken = 0;
        chk("rand_progress", {31'b0, accepts > 20}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("final_fc", fetchCount, 32'(fetch_exp));
        chk("final_sc", stallCount, 32'(stall_exp));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
